// File: rtl/fp_pipe_flow_ctrl.sv
// fp_pipe_flow_ctrl
// Credit-based flow controller wrapped around a fixed-latency, non-stalling
// floating-point pipeline. Argument handshakes are answered from a credit
// counter, launches are tracked in a latency-slot shift register, and the
// returning results are buffered in an in-order FIFO towards the consumer.
//
// Optional feature macro: FP_FLOW_CTRL_BYPASS_EN
//   When defined, a result arriving while the FIFO is empty is presented
//   directly on res/res_vld in the same cycle, cutting one cycle of latency.
//   When undefined, res/res_vld are decoded from registers only.
module fp_pipe_flow_ctrl #(
    parameter int FLEN    = 64,
    parameter int LATENCY = 5,
    parameter int DEPTH   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            arg_vld,
    output logic            arg_rdy,
    output logic            pipe_launch,
    input  logic            pipe_res_vld,
    input  logic [FLEN-1:0] pipe_res,
    output logic            res_vld,
    input  logic            res_rdy,
    output logic [FLEN-1:0] res,
    output logic            proto_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [CW-1:0]   cnt_reg;
    logic [CW-1:0]   occ_reg;
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [LATENCY-1:0] slot_reg;
    logic            proto_err_reg;
    logic [FLEN-1:0] mem [DEPTH];

    logic launch;
    logic pop;
    logic fifo_empty;
    logic fifo_full;
    logic fifo_wr;
    logic fifo_rd;
    logic slot_exp;

    // A credit is free whenever fewer than DEPTH operations are outstanding;
    // this depends on the counter register alone.
    assign arg_rdy     = (cnt_reg != CW'(DEPTH));
    assign launch      = arg_vld & arg_rdy;
    assign pipe_launch = launch;

    assign fifo_empty  = (occ_reg == '0);
    assign fifo_full   = (occ_reg == CW'(DEPTH));
    assign slot_exp    = slot_reg[LATENCY-1];

`ifdef FP_FLOW_CTRL_BYPASS_EN
    // Empty FIFO: the pipeline result is offered straight to the consumer and
    // is only stored if the consumer does not take it in this cycle.
    assign res_vld = fifo_empty ? pipe_res_vld : 1'b1;
    assign res     = fifo_empty ? pipe_res : mem[rd_ptr_reg];
    assign fifo_wr = pipe_res_vld & ~(fifo_empty & res_rdy) & (~fifo_full | res_rdy);
`else
    // Every result is stored first, so the outputs come from registers only.
    assign res_vld = ~fifo_empty;
    assign res     = mem[rd_ptr_reg];
    assign fifo_wr = pipe_res_vld & (~fifo_full | res_rdy);
`endif

    assign pop     = res_vld & res_rdy;
    assign fifo_rd = pop & ~fifo_empty;
    assign proto_err = proto_err_reg;

    // Credit counter: in-flight operations plus FIFO occupancy. The decrement
    // is guarded so a stray result under protocol violation cannot wrap it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (launch && !pop) begin
            cnt_reg <= cnt_reg + CW'(1);
        end else if (!launch && pop && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - CW'(1);
        end
    end

    // FIFO occupancy; a simultaneous write and read leaves it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_reg <= '0;
        end else if (fifo_wr && !fifo_rd) begin
            occ_reg <= occ_reg + CW'(1);
        end else if (fifo_rd && !fifo_wr) begin
            occ_reg <= occ_reg - CW'(1);
        end
    end

    // Circular write/read pointers wrapping from DEPTH-1 back to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_reg <= (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
            end
            if (fifo_rd) begin
                rd_ptr_reg <= (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
            end
        end
    end

    // Result storage; contents need no reset because occupancy gates them.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem[wr_ptr_reg] <= pipe_res;
        end
    end

    // Latency-slot tracker: the top bit marks the cycle a result is due.
    generate
        if (LATENCY == 1) begin : g_slot_one
            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_reg <= '0;
                end else begin
                    slot_reg <= launch;
                end
            end
        end else begin : g_slot_multi
            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_reg <= '0;
                end else begin
                    slot_reg <= {slot_reg[LATENCY-2:0], launch};
                end
            end
        end
    endgenerate

    // Sticky error: any result outside its slot, or a missing one, latches it.
    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err_reg <= 1'b0;
        end else if (slot_exp != pipe_res_vld) begin
            proto_err_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_pipe_flow_ctrl.sv
// Testbench for fp_pipe_flow_ctrl: models the attached fixed-latency pipeline,
// keeps a scoreboard of expected results and a credit model, and checks the
// DUT outputs every cycle on the falling clock edge.
module tb_fp_pipe_flow_ctrl;

    localparam int FLEN    = 64;
    localparam int LATENCY = 5;
    localparam int DEPTH   = 8;
`ifdef FP_FLOW_CTRL_BYPASS_EN
    localparam int RES_LAT = LATENCY;
`else
    localparam int RES_LAT = LATENCY + 1;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            arg_vld;
    logic            arg_rdy;
    logic            pipe_launch;
    logic            pipe_res_vld;
    logic [FLEN-1:0] pipe_res;
    logic            res_vld;
    logic            res_rdy;
    logic [FLEN-1:0] res;
    logic            proto_err;

    fp_pipe_flow_ctrl #(.FLEN(FLEN), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .arg_vld      (arg_vld),
        .arg_rdy      (arg_rdy),
        .pipe_launch  (pipe_launch),
        .pipe_res_vld (pipe_res_vld),
        .pipe_res     (pipe_res),
        .res_vld      (res_vld),
        .res_rdy      (res_rdy),
        .res          (res),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FLEN-1:0] data;
        int              due;
    } item_t;

    item_t pipe_q[$];
    item_t sb_q[$];
    bit    slot_hist[$];

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  m_cnt = 0;
    int  dut_launches = 0;
    int  dut_pops = 0;
    int  last_pop_cyc = -1;
    bit  m_err = 0;
    bit  chk_out = 1;
    bit  inject = 0;
    bit  drop_next = 0;
    bit  use_fixed = 0;
    bit  rst_q = 0;
    logic last_res_vld;
    logic last_arg_rdy;

    task automatic chk(input string tag, input logic [FLEN-1:0] obs, input logic [FLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_model();
        m_cnt = 0;
        m_err = 0;
        pipe_q.delete();
        sb_q.delete();
        slot_hist.delete();
        for (int i = 0; i < LATENCY; i++) slot_hist.push_back(1'b0);
    endtask

    // One clock cycle: drive pipeline outputs, check at negedge, update models.
    task automatic tick();
        bit    launch;
        bit    pop_m;
        bit    expv;
        bit    exp_vld;
        item_t it;
        pipe_res_vld = 1'b0;
        pipe_res     = {$urandom, $urandom};
        if (pipe_q.size() > 0 && pipe_q[0].due == cyc) begin
            it = pipe_q.pop_front();
            if (!drop_next) begin
                pipe_res_vld = 1'b1;
                pipe_res     = it.data;
            end
            drop_next = 0;
        end
        if (inject) begin
            pipe_res_vld = 1'b1;
            pipe_res     = 64'h0BAD_0BAD_0BAD_0BAD;
            inject       = 0;
        end
        @(negedge clk);
        last_res_vld = res_vld;
        last_arg_rdy = arg_rdy;
        exp_vld = (sb_q.size() > 0) && (sb_q[0].due <= cyc);
        if (!rst || rst_q) begin
            chk("arg_rdy", arg_rdy, (m_cnt != DEPTH));
            chk("pipe_launch", pipe_launch, arg_vld && (m_cnt != DEPTH));
            chk("proto_err", proto_err, m_err);
            if (chk_out) begin
                chk("res_vld", res_vld, exp_vld);
                if (exp_vld && res_vld) chk("res_data", res, sb_q[0].data);
            end
        end
        if (!rst) begin
            if (pipe_launch) dut_launches++;
            if (res_vld && res_rdy) dut_pops++;
            launch = arg_vld && (m_cnt != DEPTH);
            pop_m  = exp_vld && res_rdy;
            expv   = slot_hist.pop_front();
            slot_hist.push_back(launch);
            if (expv != pipe_res_vld) m_err = 1;
            if (launch) begin
                it.data = use_fixed ? 64'h4000_0000_0000_0000 : {$urandom, $urandom};
                it.due  = cyc + LATENCY;
                pipe_q.push_back(it);
                it.due  = cyc + RES_LAT;
                sb_q.push_back(it);
            end
            if (pop_m) begin
                it = sb_q.pop_front();
                last_pop_cyc = cyc;
                $display("cycle %0d pop res=%h", cyc, it.data);
            end
            m_cnt = m_cnt + int'(launch) - int'(pop_m);
        end
        @(posedge clk);
        rst_q = rst;
        if (rst) clear_model();
        cyc++;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int l0;
        int p0;
        int guard;
        clear_model();
        rst = 1'b1; arg_vld = 1'b0; res_rdy = 1'b0;
        pipe_res_vld = 1'b0; pipe_res = '0;
        // Reset: outputs idle, pipe_launch follows arg_vld while in reset.
        tick();
        arg_vld = 1'b1;
        tick();
        chk("reset_state", {res_vld, arg_rdy, proto_err, pipe_launch}, 4'b0101);

        // Single op launched at cycle 10.
        rst = 1'b0; arg_vld = 1'b0; res_rdy = 1'b1;
        while (cyc < 10) tick();
        arg_vld = 1'b1; use_fixed = 1;
        tick();
        arg_vld = 1'b0; use_fixed = 0;
        repeat (10) tick();
        chk("single_latency", last_pop_cyc, 10 + RES_LAT);
        chk("single_idle", {res_vld, arg_rdy, proto_err}, 3'b010);

        // Backpressure fill then drain.
        res_rdy = 1'b0; arg_vld = 1'b1;
        l0 = dut_launches;
        repeat (20) tick();
        chk("fill_launches", dut_launches - l0, DEPTH);
        chk("fill_arg_rdy", arg_rdy, 1'b0);
        arg_vld = 1'b0; res_rdy = 1'b1;
        p0 = dut_pops;
        repeat (12) tick();
        chk("drain_pops", dut_pops - p0, DEPTH);

        // Streaming at full throughput.
        l0 = dut_launches; p0 = dut_pops;
        arg_vld = 1'b1;
        repeat (100) tick();
        chk("stream_launches", dut_launches - l0, 100);
        arg_vld = 1'b0;
        repeat (10) tick();
        chk("stream_pops", dut_pops - p0, 100);

        // Protocol error: unexpected result.
        res_rdy = 1'b0; chk_out = 0; inject = 1;
        tick();
        repeat (4) tick();
        chk("err_unexpected", proto_err, 1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        tick();
        chk("err_cleared", proto_err, 1'b0);

        // Protocol error: missing result.
        drop_next = 1; arg_vld = 1'b1;
        tick();
        arg_vld = 1'b0;
        repeat (LATENCY + 3) tick();
        chk("err_missing", proto_err, 1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk_out = 1;
        tick();

        // Reset with 3 entries queued and 2 in flight.
        res_rdy = 1'b0; arg_vld = 1'b1;
        repeat (5) tick();
        arg_vld = 1'b0;
        repeat (3) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        tick();
        chk("rst_mid", {last_res_vld, last_arg_rdy}, 2'b01);
        repeat (3) tick();

        // Random traffic with random backpressure.
        l0 = dut_launches; p0 = dut_pops; guard = 0;
        while ((dut_launches - l0) < 1000 && guard < 20000) begin
            arg_vld = ($urandom_range(0, 2) != 0);
            res_rdy = ($urandom_range(0, 3) != 0);
            tick();
            guard++;
        end
        arg_vld = 1'b0; res_rdy = 1'b1;
        chk("rand_launches", dut_launches - l0, 1000);
        repeat (60) tick();
        chk("rand_balance", dut_pops - p0, dut_launches - l0);
        chk("rand_final", {res_vld, arg_rdy, proto_err}, 3'b010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
